// File: rtl/activation_unit_pkg.sv
// activation_unit_pkg
// Shared definitions for the activation unit:
//   - default widths (data, weight integer bits, sigmoid table input, x fraction)
//   - the ACT_TYPE names accepted by activation_unit
//   - sigmoid_s(), the constant function that fills the sigmoid ROMs
// No ports (package).
package activation_unit_pkg;

    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_WEIGHT_INT_WIDTH = 4;
    localparam int DEF_SIGMOID_SIZE     = 10;
    localparam int DEF_X_FRAC           = 5;

    localparam string ACT_RELU            = "relu";
    localparam string ACT_SIGMOID_NOR     = "sigmoid_nor";
    localparam string ACT_SIGMOID_LU_HALF = "sigmoid_lu_half";

    // Fraction bits of the fixed-point arithmetic inside sigmoid_s().
    localparam int SIG_FRAC = 62;

    // S(v) = min(round_half_up(2^(data_width-1) / (1 + e^-v)), 2^(data_width-1) - 1)
    // with v = x / 2^x_frac. Integer-only so it folds to a constant at
    // elaboration: e^-(2^-x_frac) comes from a Taylor series, then e^-|v| is
    // built by square-and-multiply over the bits of |x|.
    function automatic logic [63:0] sigmoid_s(input int x, input int data_width,
                                              input int x_frac);
        logic [127:0] one;
        logic [127:0] term;
        logic [127:0] base;
        logic [127:0] p;
        logic [127:0] r;
        logic [127:0] scale;
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] q;
        int           a;
        one  = 128'd1 << SIG_FRAC;
        base = one;
        term = one;
        for (int n = 1; n <= 16; n++) begin
            term = term / (128'(n) << x_frac);
            if ((n % 2) == 1) base = base - term;
            else              base = base + term;
        end
        a = (x < 0) ? -x : x;
        r = one;
        p = base;
        for (int k = 0; k < 31; k++) begin
            if (a[k]) r = (r * p) >> SIG_FRAC;
            p = (p * p) >> SIG_FRAC;
        end
        // For negative v use e^-|v| / (1 + e^-|v|), which equals 1 / (1 + e^|v|).
        scale = 128'd1 << (data_width - 1);
        den   = one + r;
        num   = (x < 0) ? (scale * r) : (scale << SIG_FRAC);
        q     = ((num << 1) + den) / (den << 1);
        if (q > scale - 128'd1) q = scale - 128'd1;
        return q[63:0];
    endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// sigmoid_rom
// Constant lookup table of S() values, contents fixed at elaboration.
//   HALF_MODE = 0: 2^ADDR_WIDTH entries, address is x in offset binary
//                  (address 0 is the most negative x).
//   HALF_MODE = 1: 2^ADDR_WIDTH entries for non-negative x = address.
// Ports:
//   addr  input   ADDR_WIDTH  table index
//   data  output  DATA_WIDTH  S() for that index (combinational read)
module sigmoid_rom import activation_unit_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_SIGMOID_SIZE,
    parameter int X_FRAC     = DEF_X_FRAC,
    parameter bit HALF_MODE  = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom_data [DEPTH];

    // Each entry is its own localparam so S() is evaluated at elaboration.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam int X_VAL = HALF_MODE ? i : (i - DEPTH / 2);
        localparam logic [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(sigmoid_s(X_VAL, DATA_WIDTH, X_FRAC));
        assign rom_data[i] = ENTRY;
    end

    assign data = rom_data[addr];

endmodule

// File: rtl/activation_unit.sv
// activation_unit
// One-cycle activation stage after an accumulator: relu, full-table sigmoid
// or half-table symmetric sigmoid, chosen by ACT_TYPE at elaboration.
// Ports:
//   clk        input   1             rising-edge clock
//   rst        input   1             synchronous active-high reset
//   in_valid   input   1             sum is valid this cycle
//   sum        input   2*DATA_WIDTH  signed accumulator value
//   out        output  DATA_WIDTH    registered result, held when idle
//   out_valid  output  1             in_valid delayed by one cycle
module activation_unit import activation_unit_pkg::*; #(
    parameter string ACT_TYPE         = ACT_SIGMOID_LU_HALF,
    parameter int    DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int    WEIGHT_INT_WIDTH = DEF_WEIGHT_INT_WIDTH,
    parameter int    SIGMOID_SIZE     = DEF_SIGMOID_SIZE,
    parameter int    X_FRAC           = DEF_X_FRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MAX_POS    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] HALF_SCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] act_value;

    // Each mode only looks at a window of sum; the rest is intentionally dropped.
    logic unused_sum;
    assign unused_sum = ^sum;

    if (ACT_TYPE == ACT_RELU) begin : g_relu
        logic is_neg;
        logic is_ovf;
        assign is_neg = sum[SW-1];
        assign is_ovf = |sum[SW-1 -: WEIGHT_INT_WIDTH+1];

        always_comb begin
            act_value = sum[SW-1-WEIGHT_INT_WIDTH -: DATA_WIDTH];
            if (is_neg)      act_value = '0;
            else if (is_ovf) act_value = MAX_POS;
        end
    end else if (ACT_TYPE == ACT_SIGMOID_NOR) begin : g_sigmoid_nor
        logic [SIGMOID_SIZE-1:0] x;
        logic [SIGMOID_SIZE-1:0] rom_addr;
        assign x        = sum[SW-1-WEIGHT_INT_WIDTH -: SIGMOID_SIZE];
        assign rom_addr = {~x[SIGMOID_SIZE-1], x[SIGMOID_SIZE-2:0]};

        sigmoid_rom #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (SIGMOID_SIZE),
            .X_FRAC     (X_FRAC),
            .HALF_MODE  (1'b0)
        ) u_rom (
            .addr (rom_addr),
            .data (act_value)
        );
    end else if (ACT_TYPE == ACT_SIGMOID_LU_HALF) begin : g_sigmoid_half
        logic [SIGMOID_SIZE-1:0] x;
        logic                    x_neg;
        logic [SIGMOID_SIZE-1:0] x_mag;
        logic [SIGMOID_SIZE-2:0] rom_addr;
        logic [DATA_WIDTH-1:0]   rom_value;
        assign x     = sum[SW-1-WEIGHT_INT_WIDTH -: SIGMOID_SIZE];
        // Symmetry is decided on x itself (not the sum MSB) so that a wrapped
        // x gives the same answer as the full table would.
        assign x_neg = x[SIGMOID_SIZE-1];
        assign x_mag = x_neg ? (~x + 1'b1) : x;
        // Only the most negative x has a magnitude past the table; pin it to the last entry.
        assign rom_addr = x_mag[SIGMOID_SIZE-1] ? '1 : x_mag[SIGMOID_SIZE-2:0];

        sigmoid_rom #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (SIGMOID_SIZE - 1),
            .X_FRAC     (X_FRAC),
            .HALF_MODE  (1'b1)
        ) u_rom (
            .addr (rom_addr),
            .data (rom_value)
        );

        assign act_value = x_neg ? (HALF_SCALE - rom_value) : rom_value;
    end else begin : g_bad_type
        $error("activation_unit: unsupported ACT_TYPE");
        assign act_value = '0;
    end

    // Output register: valid follows in_valid, data only loads on valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= act_value;
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit
// Drives relu, sigmoid_nor and sigmoid_lu_half instances from one stimulus
// stream and compares them against a real-arithmetic model of the functions.
module tb_activation_unit;

    localparam int DW = 16;
    localparam int SW = 32;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] sum      = '0;

    logic [DW-1:0] out_relu, out_nor, out_half;
    logic          valid_relu, valid_nor, valid_half;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [DW-1:0] exp_relu, exp_nor, exp_half;
    logic          exp_valid;

    always #5 clk = ~clk;

    activation_unit #(.ACT_TYPE("relu")) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_relu), .out_valid(valid_relu));

    activation_unit #(.ACT_TYPE("sigmoid_nor")) u_nor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_nor), .out_valid(valid_nor));

    activation_unit #(.ACT_TYPE("sigmoid_lu_half")) u_half (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .out(out_half), .out_valid(valid_half));

    // S(v) from real arithmetic, round half up, clamped to the top code.
    function automatic int model_s(input int x);
        real v;
        real s;
        int  q;
        v = real'(x) / 32.0;
        s = 32768.0 / (1.0 + $exp(-v));
        q = int'($floor(s + 0.5));
        return (q > 32767) ? 32767 : q;
    endfunction

    // x = floor(sum / 2^18) wrapped into a signed 10-bit range.
    function automatic int model_x(input logic [SW-1:0] s);
        longint q;
        q = longint'($signed(s)) >>> 18;
        q = q % 1024;
        if (q < 0) q += 1024;
        if (q >= 512) q -= 1024;
        return int'(q);
    endfunction

    function automatic int model_relu(input logic [SW-1:0] s);
        longint v;
        v = longint'($signed(s));
        if (v < 0) return 0;
        if (v >= (longint'(1) << 27)) return 32767;
        return int'(v / 4096);
    endfunction

    function automatic int model_half(input logic [SW-1:0] s);
        int x;
        int m;
        x = model_x(s);
        if (x >= 0) return model_s(x);
        m = -x;
        if (m > 511) m = 511;
        return 32768 - model_s(m);
    endfunction

    // Expected registered outputs, updated on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_valid = 1'b0;
            exp_relu  = '0;
            exp_nor   = '0;
            exp_half  = '0;
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_relu = DW'(model_relu(sum));
                exp_nor  = DW'(model_s(model_x(sum)));
                exp_half = DW'(model_half(sum));
            end
        end
    end

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        sum      = $urandom;
        repeat (2) @(negedge clk);
        n_compared += 6;
        if (out_relu !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_relu_out: got %0d expected 0", out_relu); end
        if (out_nor !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_nor_out: got %0d expected 0", out_nor); end
        if (out_half !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_half_out: got %0d expected 0", out_half); end
        if (valid_relu !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_relu_valid: got %b expected 0", valid_relu); end
        if (valid_nor !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_nor_valid: got %b expected 0", valid_nor); end
        if (valid_half !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_half_valid: got %b expected 0", valid_half); end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_relu_vectors();
        logic [SW-1:0] vec_sum [3] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0800_0000};
        logic [DW-1:0] vec_out [3] = '{16'h0010, 16'h0000, 16'h7FFF};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sum      = vec_sum[i];
            @(negedge clk);
            in_valid = 1'b0;
            n_compared += 2;
            if (out_relu !== vec_out[i]) begin n_mismatched++; $display("[TB] FAIL relu_vec sum=%h: got %h expected %h", vec_sum[i], out_relu, vec_out[i]); end
            if (valid_relu !== 1'b1) begin n_mismatched++; $display("[TB] FAIL relu_vec_valid sum=%h: got %b expected 1", vec_sum[i], valid_relu); end
        end
        @(negedge clk);
    endtask

    task automatic test_sigmoid_vectors();
        logic [SW-1:0] vec_sum  [5] = '{32'h0000_0000, 32'h0080_0000, 32'hFF80_0000, 32'h07FC_0000, 32'h0800_0000};
        logic [DW-1:0] vec_nor  [5] = '{16'd16384, 16'd23955, 16'd8813, 16'd32767, 16'd0};
        logic [DW-1:0] vec_half [5] = '{16'd16384, 16'd23955, 16'd8813, 16'd32767, 16'd1};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sum      = vec_sum[i];
            @(negedge clk);
            in_valid = 1'b0;
            n_compared += 2;
            if (out_nor !== vec_nor[i]) begin n_mismatched++; $display("[TB] FAIL sig_vec_nor sum=%h: got %0d expected %0d", vec_sum[i], out_nor, vec_nor[i]); end
            if (out_half !== vec_half[i]) begin n_mismatched++; $display("[TB] FAIL sig_vec_half sum=%h: got %0d expected %0d", vec_sum[i], out_half, vec_half[i]); end
        end
        @(negedge clk);
    endtask

    // Every x back to back, with random bits outside the x window.
    task automatic test_sweep();
        int prev_x = 0;
        int diff;
        for (int i = 0; i <= 1024; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_compared += 5;
                if (out_nor !== exp_nor) begin n_mismatched++; $display("[TB] FAIL sweep_nor x=%0d: got %0d expected %0d", prev_x, out_nor, exp_nor); end
                if (out_half !== exp_half) begin n_mismatched++; $display("[TB] FAIL sweep_half x=%0d: got %0d expected %0d", prev_x, out_half, exp_half); end
                if (valid_nor !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sweep_nor_valid x=%0d: got %b expected 1", prev_x, valid_nor); end
                if (valid_half !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sweep_half_valid x=%0d: got %b expected 1", prev_x, valid_half); end
                diff = int'(out_half) - model_s(prev_x);
                if (diff > 1 || diff < -1) begin n_mismatched++; $display("[TB] FAIL sweep_half_vs_s x=%0d: got %0d expected %0d +/-1", prev_x, out_half, model_s(prev_x)); end
            end
            if (i < 1024) begin
                prev_x   = i - 512;
                sum      = {4'($urandom), 10'(prev_x), 18'($urandom)};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Random sums with random idle cycles; checks data hold and valid timing.
    task automatic test_random();
        int kind;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_compared += 6;
                if (out_relu !== exp_relu) begin n_mismatched++; $display("[TB] FAIL rand_relu i=%0d: got %h expected %h", i, out_relu, exp_relu); end
                if (out_nor !== exp_nor) begin n_mismatched++; $display("[TB] FAIL rand_nor i=%0d: got %0d expected %0d", i, out_nor, exp_nor); end
                if (out_half !== exp_half) begin n_mismatched++; $display("[TB] FAIL rand_half i=%0d: got %0d expected %0d", i, out_half, exp_half); end
                if (valid_relu !== exp_valid) begin n_mismatched++; $display("[TB] FAIL rand_relu_valid i=%0d: got %b expected %b", i, valid_relu, exp_valid); end
                if (valid_nor !== exp_valid) begin n_mismatched++; $display("[TB] FAIL rand_nor_valid i=%0d: got %b expected %b", i, valid_nor, exp_valid); end
                if (valid_half !== exp_valid) begin n_mismatched++; $display("[TB] FAIL rand_half_valid i=%0d: got %b expected %b", i, valid_half, exp_valid); end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            kind     = $urandom_range(0, 2);
            if (kind == 0)      sum = $urandom;
            else if (kind == 1) sum = $urandom & 32'h07FF_FFFF;
            else                sum = $urandom | 32'hF800_0000;
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] hs_sum   [4] = '{32'h0001_0000, 32'h0002_3000, 32'h1234_5678, 32'h0000_8000};
        logic          hs_valid [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic          want_vld [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] want_out [5] = '{16'h0000, 16'h0010, 16'h0023, 16'h0023, 16'h0008};
        in_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j <= 4; j++) begin
            n_compared++;
            if (valid_relu !== want_vld[j]) begin n_mismatched++; $display("[TB] FAIL hs_valid step=%0d: got %b expected %b", j, valid_relu, want_vld[j]); end
            if (j > 0) begin
                n_compared++;
                if (out_relu !== want_out[j]) begin n_mismatched++; $display("[TB] FAIL hs_out step=%0d: got %h expected %h", j, out_relu, want_out[j]); end
            end
            if (j < 4) begin
                in_valid = hs_valid[j];
                sum      = hs_sum[j];
                @(negedge clk);
            end
        end
        // Reset in the middle of a valid stream, then resume.
        in_valid = 1'b1;
        sum      = 32'h0080_0000;
        rst      = 1'b1;
        @(negedge clk);
        n_compared += 4;
        if (out_nor !== 16'd0) begin n_mismatched++; $display("[TB] FAIL midrst_nor_out: got %0d expected 0", out_nor); end
        if (out_half !== 16'd0) begin n_mismatched++; $display("[TB] FAIL midrst_half_out: got %0d expected 0", out_half); end
        if (out_relu !== 16'd0) begin n_mismatched++; $display("[TB] FAIL midrst_relu_out: got %0d expected 0", out_relu); end
        if (valid_half !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid_half); end
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_compared += 4;
        if (out_nor !== 16'd23955) begin n_mismatched++; $display("[TB] FAIL postrst_nor: got %0d expected 23955", out_nor); end
        if (out_half !== 16'd23955) begin n_mismatched++; $display("[TB] FAIL postrst_half: got %0d expected 23955", out_half); end
        if (out_relu !== 16'h0800) begin n_mismatched++; $display("[TB] FAIL postrst_relu: got %h expected 0800", out_relu); end
        if (valid_nor !== 1'b1) begin n_mismatched++; $display("[TB] FAIL postrst_valid: got %b expected 1", valid_nor); end
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] activation_unit bench start");
        test_reset();
        test_relu_vectors();
        test_sigmoid_vectors();
        test_sweep();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
